hazard_stall_ctrl: RTL and testbench

//   Pipeline sequencing controller paired with the EX-stage forwarding logic.

---
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch-flush / memory-freeze pipeline sequencing controller
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        if_id_rs,
  input  logic [4:0]        if_id_rt,
  input  logic [4:0]        id_ex_rt,
  input  logic              id_ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              pipe_hold,
  output logic              mem_timeout_err,
  output logic [1:0]        ctrl_state,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  logic [1:0] state, state_nxt;
  logic [2:0] bub_cnt, bub_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err, err_nxt;
  logic       lu, mw;
  logic       pc_w, ifid_w, bub, flush, hold;

  assign lu = id_ex_mem_read && (id_ex_rt != 5'd0) &&
              ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign mw = mem_req && !mem_ready;

  always_comb begin
    state_nxt    = state;
    bub_cnt_nxt  = bub_cnt;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err;
    pc_w         = 1'b1;
    ifid_w       = 1'b1;
    bub          = 1'b0;
    flush        = 1'b0;
    hold         = 1'b0;
    case (state)
      ST_MEM_WAIT: begin
        // Branch resolution is deliberately ignored here: the branch stays in EX until the freeze ends.
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        hold   = 1'b1;
        if (mem_ready) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = (state == ST_LU_STALL) ? ST_LU_STALL : ST_RUN;
        if (mw) begin
          pc_w         = 1'b0;
          ifid_w       = 1'b0;
          hold         = 1'b1;
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = 8'd1;
          bub_cnt_nxt  = 3'd0;
        end else if (ex_branch_taken) begin
          flush       = 1'b1;
          bub         = 1'b1;
          ifid_w      = 1'b0;
          state_nxt   = ST_RUN;
          bub_cnt_nxt = 3'd0;
        end else if ((state == ST_LU_STALL) || lu) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          bub    = 1'b1;
          if (state == ST_LU_STALL) begin
            bub_cnt_nxt = bub_cnt - 3'd1;
            if (bub_cnt == 3'd1) state_nxt = ST_RUN;
          end else if (LU_BUBBLES > 1) begin
            state_nxt   = ST_LU_STALL;
            bub_cnt_nxt = 3'(LU_BUBBLES - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      bub_cnt  <= 3'd0;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      bub_cnt  <= bub_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      err      <= err_nxt;
    end
  end

  // Reset forces a safe "insert NOP, advance nothing" output pattern regardless of inputs.
  assign pc_write        = rst_n & pc_w;
  assign if_id_write     = rst_n & ifid_w;
  assign id_ex_bubble    = ~rst_n | bub;
  assign if_id_flush     = rst_n & flush;
  assign pipe_hold       = rst_n & hold;
  assign mem_timeout_err = err;
  assign ctrl_state      = state;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_w && (stall_q != {PERF_W{1'b1}})) stall_q <= stall_q + PERF_W'(1);
      if (flush && (flush_q != {PERF_W{1'b1}})) flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed scenarios plus randomized run against a behavioural model
module tb_hazard_stall_ctrl;

  localparam int LUB = 2;
  localparam int MT  = 6;
  localparam int PW  = 8;
`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // Packed view: {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, err, state[1:0]}
  localparam logic [7:0] V_RESET      = 8'b0010_0000;
  localparam logic [7:0] V_NORM       = 8'b1100_0000;
  localparam logic [7:0] V_STALL_RUN  = 8'b0010_0000;
  localparam logic [7:0] V_STALL_LU   = 8'b0010_0001;
  localparam logic [7:0] V_FREEZE_RUN = 8'b0000_1000;
  localparam logic [7:0] V_FREEZE_MW  = 8'b0000_1010;
  localparam logic [7:0] V_FLUSH_LU   = 8'b1011_0001;
  localparam logic [7:0] V_NORM_ERR   = 8'b1100_0100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    if_id_rs, if_id_rt, id_ex_rt;
  logic          id_ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, mem_timeout_err;
  logic [1:0]    ctrl_state;
  logic [PW-1:0] stall_cycles, flush_count;
  logic [7:0]    outs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign outs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, mem_timeout_err, ctrl_state};

  hazard_stall_ctrl #(.LU_BUBBLES(LUB), .MEM_TIMEOUT(MT), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_ex_rt(id_ex_rt),
    .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .pipe_hold(pipe_hold), .mem_timeout_err(mem_timeout_err),
    .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic drive_idle();
    if_id_rs = 5'd1; if_id_rt = 5'd2; id_ex_rt = 5'd3;
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #2;
    vectors++;
    if (outs !== V_RESET) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", outs, V_RESET);
    end
    vectors++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    tick();
    drive_idle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (outs !== V_NORM) begin
      miscompares++;
      $display("FAIL reset_release: got %b expected %b", outs, V_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive_idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8; if_id_rs = 5'd8;
    #1;
    vectors++;
    if (outs !== V_STALL_RUN) begin
      miscompares++;
      $display("FAIL lu_first_stall: got %b expected %b", outs, V_STALL_RUN);
    end
    tick();
    id_ex_mem_read = 1'b0;
    #1;
    vectors++;
    if (outs !== V_STALL_LU) begin
      miscompares++;
      $display("FAIL lu_second_stall: got %b expected %b", outs, V_STALL_LU);
    end
    tick();
    #1;
    vectors++;
    if (outs !== V_NORM) begin
      miscompares++;
      $display("FAIL lu_resume: got %b expected %b", outs, V_NORM);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive_idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    #1;
    vectors++;
    if (outs !== V_NORM) begin
      miscompares++;
      $display("FAIL lu_r0_no_stall: got %b expected %b", outs, V_NORM);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    drive_idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) mem_ready = 1'b1;
      #1;
      vectors++;
      if (outs !== ((i == 0) ? V_FREEZE_RUN : V_FREEZE_MW)) begin
        miscompares++;
        $display("FAIL mem_wait_hold[%0d]: got %b expected %b", i, outs,
                 (i == 0) ? V_FREEZE_RUN : V_FREEZE_MW);
      end
      tick();
    end
    drive_idle();
    #1;
    vectors++;
    if (outs !== V_NORM) begin
      miscompares++;
      $display("FAIL mem_wait_exit: got %b expected %b", outs, V_NORM);
    end
    tick();
  endtask

  task automatic test_branch_in_lu_stall();
    drive_idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd9; if_id_rt = 5'd9;
    tick();
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b1;
    #1;
    vectors++;
    if (outs !== V_FLUSH_LU) begin
      miscompares++;
      $display("FAIL branch_in_lu_stall: got %b expected %b", outs, V_FLUSH_LU);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    vectors++;
    if (outs !== V_NORM) begin
      miscompares++;
      $display("FAIL branch_abort_bubbles: got %b expected %b", outs, V_NORM);
    end
    // Stalls so far: 2 (load-use) + 5 (freeze) + 1 (this load-use) = 8; one flush.
    vectors++;
    if (stall_cycles !== (PERF_ON ? PW'(8) : PW'(0)) ||
        flush_count  !== (PERF_ON ? PW'(1) : PW'(0))) begin
      miscompares++;
      $display("FAIL perf_directed: got %0d/%0d expected %0d/%0d", stall_cycles, flush_count,
               PERF_ON ? 8 : 0, PERF_ON ? 1 : 0);
    end
    tick();
  endtask

  task automatic test_timeout();
    drive_idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    vectors++;
    if (outs !== V_FREEZE_RUN) begin
      miscompares++;
      $display("FAIL timeout_entry: got %b expected %b", outs, V_FREEZE_RUN);
    end
    tick();
    for (int k = 1; k <= MT; k++) begin
      vectors++;
      if (outs !== V_FREEZE_MW) begin
        miscompares++;
        $display("FAIL timeout_wait[%0d]: got %b expected %b", k, outs, V_FREEZE_MW);
      end
      tick();
    end
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (outs !== V_NORM_ERR) begin
        miscompares++;
        $display("FAIL timeout_err_sticky[%0d]: got %b expected %b", k, outs, V_NORM_ERR);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_mem_wait();
    drive_idle();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs !== V_RESET) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got %b expected %b", outs, V_RESET);
    end
    vectors++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
    end
    tick();
    drive_idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int  stalls_left = 0;
    int  waited = 0;
    bit  waiting = 0;
    bit  err = 0;
    int  sc = 0;
    int  fc = 0;
    int  bias = 8;
    bit  lu, mw;
    logic [7:0] exp_v;
    int  exp_state;
    logic [PW-1:0] exp_sc, exp_fc;
    int  sat = (1 << PW) - 1;

    rst_n = 1'b0;
    drive_idle();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) bias = (n % 1200 == 0) ? 8 : ((n % 800 == 0) ? 3 : 1);
      id_ex_rt        = 5'($urandom_range(0, 3));
      if_id_rs        = 5'($urandom_range(0, 3));
      if_id_rt        = 5'($urandom_range(0, 3));
      id_ex_mem_read  = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = ($urandom_range(0, 5) == 0);
      mem_ready       = ($urandom_range(0, 9) < bias);
      #2;
      lu = id_ex_mem_read && id_ex_rt != 0 && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
      mw = mem_req && !mem_ready;
      exp_state = waiting ? 2 : ((stalls_left > 0) ? 1 : 0);
      // Expected outputs: {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold}
      if (waiting || mw)                exp_v[7:3] = 5'b00001;
      else if (ex_branch_taken)         exp_v[7:3] = 5'b10110;
      else if (stalls_left > 0 || lu)   exp_v[7:3] = 5'b00100;
      else                              exp_v[7:3] = 5'b11000;
      exp_v[2]   = err;
      exp_v[1:0] = 2'(exp_state);
      exp_sc = PERF_ON ? PW'(sc) : PW'(0);
      exp_fc = PERF_ON ? PW'(fc) : PW'(0);
      vectors++;
      if (outs !== exp_v || stall_cycles !== exp_sc || flush_count !== exp_fc) begin
        miscompares++;
        $display("FAIL random[%0d]: got %b sc=%0d fc=%0d expected %b sc=%0d fc=%0d",
                 n, outs, stall_cycles, flush_count, exp_v, exp_sc, exp_fc);
      end
      if (!exp_v[7] && sc < sat) sc++;
      if (exp_v[4] && fc < sat) fc++;
      if (waiting) begin
        if (mem_ready) waiting = 0;
        else if (waited == MT) begin err = 1; waiting = 0; end
        else waited++;
      end else if (mw) begin
        waiting = 1; waited = 1; stalls_left = 0;
      end else if (ex_branch_taken) begin
        stalls_left = 0;
      end else if (stalls_left > 0) begin
        stalls_left--;
      end else if (lu) begin
        stalls_left = LUB - 1;
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_mem_wait();
    test_branch_in_lu_stall();
    test_timeout();
    test_reset_in_mem_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
